// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and constants for the ingress FIFO drain arbiter.
// The state encoding is one-hot.
package fifo_drain_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_IDX_W  = 10;

  localparam logic       SRC_VARINT   = 1'b0;
  localparam logic       SRC_RAW      = 1'b1;
  localparam logic [3:0] VARINT_WSTRB = 4'hF;

  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    SERVE_V = 3'b010,
    SERVE_R = 3'b100
  } arb_state_e;

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Bundle of the two show-ahead FIFO heads plus the downstream valid/ready word port.
// The arbiter uses the master modport; the FIFOs and encoder use the slave modport.
interface fifo_drain_arbiter_if
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) ();

  logic              varint_empty;
  logic [DATA_W-1:0] varint_data;
  logic [IDX_W-1:0]  varint_index;
  logic              varint_pop;

  logic              raw_empty;
  logic [DATA_W-1:0] raw_data;
  logic [IDX_W-1:0]  raw_index;
  logic [3:0]        raw_wstrb;
  logic              raw_pop;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_wstrb;
  logic [IDX_W-1:0]  out_index;
  logic              out_src;
  logic              out_first;
  logic              busy;

  modport master (
    input  varint_empty, varint_data, varint_index,
    output varint_pop,
    input  raw_empty, raw_data, raw_index, raw_wstrb,
    output raw_pop,
    output out_valid, out_data, out_wstrb, out_index, out_src, out_first, busy,
    input  out_ready
  );

  modport slave (
    output varint_empty, varint_data, varint_index,
    input  varint_pop,
    output raw_empty, raw_data, raw_index, raw_wstrb,
    input  raw_pop,
    input  out_valid, out_data, out_wstrb, out_index, out_src, out_first, busy,
    output out_ready
  );

endinterface

// File: rtl/fifo_drain_arbiter_drain_out_reg.sv
// One-entry registered valid/ready output stage.
// A load overrides a same-cycle ready, so the held word is replaced without a gap.
module drain_out_reg
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  index_i,
  input  logic [3:0]        wstrb_i,
  input  logic              src_i,
  input  logic              first_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  index_o,
  output logic [3:0]        wstrb_o,
  output logic              src_o,
  output logic              first_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q;
  logic [IDX_W-1:0]  index_q;
  logic [3:0]        wstrb_q;
  logic              src_q;
  logic              first_q;

  always_comb begin
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      wstrb_q <= '0;
      src_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q  <= data_i;
        index_q <= index_i;
        wstrb_q <= wstrb_i;
        src_q   <= src_i;
        first_q <= first_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign index_o = index_q;
  assign wstrb_o = wstrb_q;
  assign src_o   = src_q;
  assign first_o = first_q;

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of the varint and raw ingress FIFOs into one encoder port.
// A grant holds one source for a contiguous run of equal indices, capped at MAX_BURST words.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned IDX_W     = DEF_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_drain_arbiter_if.master bus
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  arb_state_e        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [IDX_W-1:0]  lock_q, lock_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              out_valid;
  logic              can_load;
  logic              v_ok, r_ok;
  logic              pop_v, pop_r;
  logic [DATA_W-1:0] ld_data;
  logic [IDX_W-1:0]  ld_index;
  logic [3:0]        ld_wstrb;

  assign can_load = ~out_valid | bus.out_ready;
  assign v_ok = ~bus.varint_empty & (bus.varint_index == lock_q) & (cnt_q < BURST_MAX);
  assign r_ok = ~bus.raw_empty & (bus.raw_index == lock_q) & (cnt_q < BURST_MAX);

  // An out_ready stall only withholds the pop; the grant ends solely when the head itself disqualifies.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    pop_v     = 1'b0;
    pop_r     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (~bus.varint_empty & (bus.raw_empty | (rr_last_q == SRC_RAW))) begin
          state_d = SERVE_V;
          lock_d  = bus.varint_index;
          cnt_d   = '0;
        end else if (~bus.raw_empty) begin
          state_d = SERVE_R;
          lock_d  = bus.raw_index;
          cnt_d   = '0;
        end
      end
      SERVE_V: begin
        if (!v_ok) begin
          state_d   = IDLE;
          rr_last_d = SRC_VARINT;
        end else if (can_load) begin
          pop_v = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      SERVE_R: begin
        if (!r_ok) begin
          state_d   = IDLE;
          rr_last_d = SRC_RAW;
        end else if (can_load) begin
          pop_r = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      pop_v = 1'b0;
      pop_r = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= SRC_RAW;
      lock_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ld_data  = pop_r ? bus.raw_data  : bus.varint_data;
  assign ld_index = pop_r ? bus.raw_index : bus.varint_index;
  assign ld_wstrb = pop_r ? bus.raw_wstrb : VARINT_WSTRB;

  drain_out_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (pop_v | pop_r),
    .ready_i (bus.out_ready),
    .data_i  (ld_data),
    .index_i (ld_index),
    .wstrb_i (ld_wstrb),
    .src_i   (pop_r),
    .first_i (cnt_q == 8'd0),
    .valid_o (out_valid),
    .data_o  (bus.out_data),
    .index_o (bus.out_index),
    .wstrb_o (bus.out_wstrb),
    .src_o   (bus.out_src),
    .first_o (bus.out_first)
  );

  assign bus.varint_pop = pop_v;
  assign bus.raw_pop    = pop_r;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = (state_q != IDLE) | out_valid;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Scoreboard bench for fifo_drain_arbiter: queue-backed show-ahead FIFO models feed the DUT,
// expected words are queued as stimulus is issued and compared on each output handshake.
module tb_fifo_drain_arbiter;
  import fifo_drain_arbiter_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 10;
  localparam int unsigned MB = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] idx;
    logic [3:0]    s;
  } fw_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] idx;
    logic [3:0]    s;
    logic          src;
    logic          first;
  } ex_t;

  logic clk = 1'b0;
  logic reset;

  fifo_drain_arbiter_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

  fifo_drain_arbiter #(
    .MAX_BURST (MB),
    .DATA_W    (DW),
    .IDX_W     (IW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  fw_t         vq[$];
  fw_t         rq[$];
  ex_t         expq[$];
  int unsigned vstamp[$];
  int unsigned rstamp[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  int unsigned xfers  = 0;

  // FIFO models: heads follow the queue fronts; a pop seen at an edge retires the front.
  logic vp_s, rp_s;
  fw_t  tmp_w;

  function automatic void refresh_heads();
    bus.varint_empty = (vq.size() == 0);
    bus.varint_data  = (vq.size() != 0) ? vq[0].d   : '0;
    bus.varint_index = (vq.size() != 0) ? vq[0].idx : '0;
    bus.raw_empty    = (rq.size() == 0);
    bus.raw_data     = (rq.size() != 0) ? rq[0].d   : '0;
    bus.raw_index    = (rq.size() != 0) ? rq[0].idx : '0;
    bus.raw_wstrb    = (rq.size() != 0) ? rq[0].s   : '0;
  endfunction

  always begin
    refresh_heads();
    @(posedge clk);
    cyc++;
    vp_s = bus.varint_pop;
    rp_s = bus.raw_pop;
    if (vp_s) begin
      checks++;
      if (vq.size() == 0) begin
        errors++;
        $display("FAIL pop_empty_varint: varint_pop=1 with FIFO empty, required 0");
      end else begin
        vstamp.push_back(cyc);
      end
    end
    if (rp_s) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL pop_empty_raw: raw_pop=1 with FIFO empty, required 0");
      end else begin
        rstamp.push_back(cyc);
      end
    end
    #1;
    if (vp_s && vq.size() != 0) tmp_w = vq.pop_front();
    if (rp_s && rq.size() != 0) tmp_w = rq.pop_front();
  end

  // Output monitor: handshake compare against the scoreboard plus hold-stability while stalled.
  logic        hold_s = 1'b0;
  logic [47:0] held_s;
  logic [47:0] got_s, exp_s;
  ex_t         e_s;

  always @(negedge clk) begin
    if (reset) begin
      hold_s = 1'b0;
    end else begin
      got_s = {bus.out_data, bus.out_index, bus.out_wstrb, bus.out_src, bus.out_first};
      if (hold_s) begin
        checks++;
        if (!bus.out_valid || got_s !== held_s) begin
          errors++;
          $display("FAIL stall_stable: valid=%0b payload=%h, required valid=1 payload=%h",
                   bus.out_valid, got_s, held_s);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        xfers++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got payload=%h, required no word", got_s);
        end else begin
          e_s   = expq.pop_front();
          exp_s = {e_s.d, e_s.idx, e_s.s, e_s.src, e_s.first};
          if (got_s !== exp_s) begin
            errors++;
            $display("FAIL word: got data=%h idx=%0d wstrb=%h src=%0b first=%0b, required data=%h idx=%0d wstrb=%h src=%0b first=%0b",
                     bus.out_data, bus.out_index, bus.out_wstrb, bus.out_src, bus.out_first,
                     e_s.d, e_s.idx, e_s.s, e_s.src, e_s.first);
          end
        end
      end
      hold_s = bus.out_valid && !bus.out_ready;
      held_s = got_s;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_v(input logic [DW-1:0] d, input logic [IW-1:0] idx, input logic first);
    fw_t w;
    ex_t e;
    w.d = d; w.idx = idx; w.s = 4'h0;
    vq.push_back(w);
    e.d = d; e.idx = idx; e.s = VARINT_WSTRB; e.src = SRC_VARINT; e.first = first;
    expq.push_back(e);
  endtask

  task automatic push_r(input logic [DW-1:0] d, input logic [IW-1:0] idx, input logic [3:0] s,
                        input logic first);
    fw_t w;
    ex_t e;
    w.d = d; w.idx = idx; w.s = s;
    rq.push_back(w);
    e.d = d; e.idx = idx; e.s = s; e.src = SRC_RAW; e.first = first;
    expq.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    step();
    while ((vq.size() != 0 || rq.size() != 0 || expq.size() != 0 || bus.busy) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_%s: %0d words still expected after 200 cycles, required 0",
               name, expq.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%0b busy=%0b, required 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if ({bus.out_data, bus.out_index, bus.out_wstrb, bus.out_src, bus.out_first} !== 48'h0) begin
      errors++;
      $display("FAIL reset_payload: data=%h idx=%0d wstrb=%h src=%0b first=%0b, required all 0",
               bus.out_data, bus.out_index, bus.out_wstrb, bus.out_src, bus.out_first);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.varint_pop !== 1'b0 || bus.raw_pop !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: vpop=%0b rpop=%0b busy=%0b, required 0 0 0",
               bus.varint_pop, bus.raw_pop, bus.busy);
    end
  endtask

  task automatic test_single_record();
    vstamp.delete(); rstamp.delete();
    for (int i = 0; i < 3; i++) push_v(32'hA000_0000 + i, 10'd5, i == 0);
    wait_drain("single");
    checks++;
    if (vstamp.size() != 3 || rstamp.size() != 0) begin
      errors++;
      $display("FAIL single_pops: vpops=%0d rpops=%0d, required 3 0", vstamp.size(), rstamp.size());
    end else begin
      checks++;
      if (vstamp[2] - vstamp[0] != 2) begin
        errors++;
        $display("FAIL single_back_to_back: pop span=%0d cycles, required 2", vstamp[2] - vstamp[0]);
      end
    end
  endtask

  task automatic test_tie_after_reset();
    do_reset();
    vstamp.delete(); rstamp.delete();
    push_v(32'hB000_0000, 10'd0, 1'b1);
    push_v(32'hB000_0001, 10'd0, 1'b0);
    push_r(32'hC000_0000, 10'd0, 4'h3, 1'b1);
    push_r(32'hC000_0001, 10'd0, 4'h3, 1'b0);
    wait_drain("tie");
    checks++;
    if (vstamp.size() != 2 || rstamp.size() != 2) begin
      errors++;
      $display("FAIL tie_pops: vpops=%0d rpops=%0d, required 2 2", vstamp.size(), rstamp.size());
    end else begin
      checks++;
      if (rstamp[0] - vstamp[1] != 3) begin
        errors++;
        $display("FAIL tie_bubble: last varint to first raw pop=%0d cycles, required 3",
                 rstamp[0] - vstamp[1]);
      end
    end
  endtask

  task automatic test_max_burst();
    do_reset();
    vstamp.delete(); rstamp.delete();
    for (int i = 0; i < 8; i++) push_v(32'hD000_0000 + i, 10'd7, i == 0);
    push_r(32'hE000_0000, 10'd3, 4'hA, 1'b1);
    push_r(32'hE000_0001, 10'd3, 4'hA, 1'b0);
    for (int i = 8; i < 12; i++) push_v(32'hD000_0000 + i, 10'd7, i == 8);
    wait_drain("burst");
    checks++;
    if (vstamp.size() != 12 || rstamp.size() != 2) begin
      errors++;
      $display("FAIL burst_pops: vpops=%0d rpops=%0d, required 12 2", vstamp.size(), rstamp.size());
    end else begin
      checks++;
      if (vstamp[7] - vstamp[0] != 7 || rstamp[0] <= vstamp[7] || vstamp[8] <= rstamp[1]) begin
        errors++;
        $display("FAIL burst_order: v0=%0d v7=%0d r0=%0d r1=%0d v8=%0d, required v7-v0=7 and v7<r0<r1<v8",
                 vstamp[0], vstamp[7], rstamp[0], rstamp[1], vstamp[8]);
      end
    end
  endtask

  task automatic test_index_wrap();
    vstamp.delete(); rstamp.delete();
    push_v(32'hF000_0000, 10'd1023, 1'b1);
    push_v(32'hF000_0001, 10'd1023, 1'b0);
    push_v(32'hF000_0002, 10'd0,    1'b1);
    wait_drain("wrap");
    checks++;
    if (vstamp.size() != 3) begin
      errors++;
      $display("FAIL wrap_pops: vpops=%0d, required 3", vstamp.size());
    end else begin
      checks++;
      if (vstamp[2] - vstamp[1] != 3) begin
        errors++;
        $display("FAIL wrap_regrant: gap=%0d cycles, required 3", vstamp[2] - vstamp[1]);
      end
    end
  endtask

  task automatic test_stall();
    int unsigned base;
    int n = 0;
    vstamp.delete(); rstamp.delete();
    base = xfers;
    for (int i = 0; i < 6; i++) push_v(32'h1234_0000 + i, 10'd9, i == 0);
    while (xfers < base + 2 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL stall_start: %0d words seen, required 2", xfers - base);
    end
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (bus.varint_pop !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d vpop=%0b valid=%0b, required 0 1",
                 c, bus.varint_pop, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    wait_drain("stall");
    checks++;
    if (vstamp.size() != 6) begin
      errors++;
      $display("FAIL stall_pops: vpops=%0d, required 6", vstamp.size());
    end
  endtask

  task automatic test_reset_mid_grant();
    int unsigned base;
    int n = 0;
    base = xfers;
    for (int i = 0; i < 6; i++) push_v(32'h5500_0000 + i, 10'd2, i == 0);
    while (xfers < base + 2 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL rstmid_start: %0d words seen, required 2", xfers - base);
    end
    bus.out_ready = 1'b0;
    rq.push_back('{d: 32'h6600_0000, idx: 10'd4, s: 4'h5});
    rq.push_back('{d: 32'h6600_0001, idx: 10'd4, s: 4'h5});
    step();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.varint_pop !== 1'b0 || bus.raw_pop !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pop: vpop=%0b rpop=%0b during reset, required 0 0",
               bus.varint_pop, bus.raw_pop);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    checks++;
    if ({bus.out_valid, bus.busy, bus.out_first, bus.out_src} !== 4'b0 ||
        {bus.out_data, bus.out_index, bus.out_wstrb} !== 46'h0) begin
      errors++;
      $display("FAIL rstmid_clear: valid=%0b busy=%0b first=%0b src=%0b data=%h idx=%0d wstrb=%h, required all 0",
               bus.out_valid, bus.busy, bus.out_first, bus.out_src,
               bus.out_data, bus.out_index, bus.out_wstrb);
    end
    // Word 2 was in the output register and is dropped; words 3..5 and the raw pair remain queued.
    expq.delete();
    vstamp.delete(); rstamp.delete();
    for (int i = 3; i < 6; i++) begin
      expq.push_back('{d: 32'h5500_0000 + i, idx: 10'd2, s: VARINT_WSTRB, src: SRC_VARINT, first: (i == 3)});
    end
    expq.push_back('{d: 32'h6600_0000, idx: 10'd4, s: 4'h5, src: SRC_RAW, first: 1'b1});
    expq.push_back('{d: 32'h6600_0001, idx: 10'd4, s: 4'h5, src: SRC_RAW, first: 1'b0});
    wait_drain("rstmid");
    checks++;
    if (vstamp.size() != 3 || rstamp.size() != 2) begin
      errors++;
      $display("FAIL rstmid_pops: vpops=%0d rpops=%0d, required 3 2", vstamp.size(), rstamp.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_record();
    test_tie_after_reset();
    test_max_burst();
    test_index_wrap();
    test_stall();
    test_reset_mid_grant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Drains the two ingress FIFOs filled by the AXI4 write-slave FSM (varint_in and raw_data_in) and shares the single downstream encoder port between them. Grants are round-robin, but a grant stays on one source for a whole record (contiguous run of equal index values), up to MAX_BURST words. Output is a one-entry registered valid/ready stage.

## Interface

- MAX_BURST, 8, maximum words popped per grant (legal 1..255)
- DATA_W, 32, FIFO data width
- IDX_W, 10, record index width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- varint_empty  in  1  varint FIFO empty (show-ahead FIFO: head valid when low)
- varint_data  in  DATA_W  varint FIFO head data
- varint_index  in  IDX_W  varint FIFO head index
- varint_pop  out  1  advance varint FIFO
- raw_empty  in  1  raw-data FIFO empty (show-ahead)
- raw_data  in  DATA_W  raw FIFO head data
- raw_index  in  IDX_W  raw FIFO head index
- raw_wstrb  in  4  raw FIFO head byte strobes
- raw_pop  out  1  advance raw FIFO
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  word
- out_wstrb  out  4  byte strobes (4'hF for varint words)
- out_index  out  IDX_W  record index
- out_src  out  1  0 = varint, 1 = raw
- out_first  out  1  first word of a grant
- busy  out  1  state != IDLE or out_valid

## Operation

- States: IDLE, SERVE_V, SERVE_R (one-hot).
- IDLE: if neither FIFO non-empty, stay. If one non-empty, go to its SERVE state. If both, pick the source not served last. rr_last resets to raw, so varint wins the first tie. On transition, capture lock_index from the chosen head index and clear burst_cnt. No pop in IDLE.
- SERVE_x: `pop = ~x_empty & (x_index == lock_index) & (burst_cnt < MAX_BURST) & (~out_valid | out_ready)`.
  - A pop loads the output register at that edge: data, index, wstrb, src.
  - out_first = 1 on the first pop of the grant.
  - burst_cnt increments on each pop.
- SERVE_x exits to IDLE in the cycle pop would be 0 because of any of: x_empty, index mismatch, or burst_cnt == MAX_BURST. A stall caused only by out_ready does not end the grant. rr_last <= x on exit.
- Output register: out_valid sets on pop. It clears on `out_ready & ~pop`. Pop with out_ready replaces the word in the same cycle.
- Pops are combinational from registered state and current inputs. A pop is never asserted while the FIFO is empty or during reset.
- Index compare is equality only. A wrap 1023 -> 0 counts as a new record and ends the grant.
- Reset (any time, including mid-grant): state IDLE, out_valid/out_first/out_src/varint_pop/raw_pop/busy = 0, data/index/wstrb = 0, burst_cnt = 0, lock_index = 0, rr_last = raw. Any word held in the output register is discarded.

## Timing

- Pop-to-out_valid: 1 cycle.
- Arbitration bubble: exactly 1 IDLE cycle between grants.
- Sustained throughput within a grant: 1 word/clk while out_ready = 1.
- Empty-to-first-pop after a FIFO goes non-empty from IDLE: 1 cycle.
- out_* stay stable while out_valid & ~out_ready.

## Structure

- Shared package: state encodings, SRC_VARINT = 1'b0, SRC_RAW = 1'b1, DATA_W/IDX_W defaults, VARINT_WSTRB = 4'hF.
- One sub-module: drain_out_reg, a one-entry valid/ready output register (load, ready, payload).
- Arbiter FSM, burst counter and lock_index stay in fifo_drain_arbiter.

## Test plan

- Reset, then varint FIFO holds 3 words with index 5 and raw FIFO is empty, out_ready = 1. Expect 3 consecutive varint_pop and out_index = 5 on all words, out_first only on the first, wstrb = F, then IDLE.
- Both FIFOs non-empty after reset (varint idx 0 ×2, raw idx 0 ×2, raw_wstrb = 4'h3). Expect varint words, 1 bubble, then raw words with out_src = 1 and out_wstrb = 3.
- MAX_BURST = 8 and 12 varint words of index 7 with raw non-empty. Expect 8 varint pops, then a raw grant, then the remaining 4 varint words.
- Varint heads with index 1023, 1023, 0. Expect the grant to end after the second word and the word with index 0 to be served by a new grant (out_first = 1).
- out_ready held low for 5 cycles mid-grant. Expect out_* held stable, no pops, grant retained, and no words lost or duplicated afterwards.
- Reset asserted while out_valid = 1 mid-grant. Expect all outputs 0 the next cycle and a fresh arbitration with varint priority.
